// File: rtl/rr_mux4_arbiter_if.sv
// Requester-side bundle of the round-robin 4:1 mux arbiter:
// request/data in, grant/select/busy/data out.
interface rr_mux4_arbiter_if #(
  parameter int W = 1
);
  logic [3:0]   req;
  logic [W-1:0] i0;
  logic [W-1:0] i1;
  logic [W-1:0] i2;
  logic [W-1:0] i3;
  logic [3:0]   gnt;
  logic         s1;
  logic         s0;
  logic         busy;
  logic [W-1:0] y;

  modport master (
    output req, i0, i1, i2, i3,
    input  gnt, s1, s0, busy, y
  );

  modport slave (
    input  req, i0, i1, i2, i3,
    output gnt, s1, s0, busy, y
  );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux datapath.
// Define MUX_ARB_TIMEOUT_EN to force-release grants after MAX_HOLD cycles.
module rr_mux4_arbiter #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 8
) (
  input logic             clk,
  input logic             rst_n,
  rr_mux4_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;

  logic [1:0] win;
  logic       win_vld;
  logic [1:0] idx;
  logic       hold_hit;

  // Scan from farthest to nearest so the offset closest to ptr wins.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    idx     = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (bus.req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  logic [7:0] cnt_q, cnt_d;

  assign hold_hit = (cnt_q == HOLD_LIM);

  always_comb begin
    cnt_d = 8'd0;
    if (state_q == GRANT) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
`else
  logic [7:0] unused_hold;

  assign unused_hold = 8'(MAX_HOLD);
  assign hold_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          sel_d   = win;
          gnt_d   = 4'b0001 << win;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q] || hold_hit) begin
          state_d = IDLE;
          ptr_d   = sel_q + 2'd1;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    bus.y = '0;
    if (busy_q) begin
      unique case (sel_q)
        2'd0:    bus.y = bus.i0;
        2'd1:    bus.y = bus.i1;
        2'd2:    bus.y = bus.i2;
        default: bus.y = bus.i3;
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.s1   = sel_q[1];
  assign bus.s0   = sel_q[0];
  assign bus.busy = busy_q;

endmodule
